ccd_frame_sender: RTL and testbench
===================================

CCD_FRAME_SENDER -- requirements
Module: ccd_frame_sender

Interface
REQ-001 Parameter CLK_DIV, default 434, is the number of clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter FRAME_LEN, default 1024, is the number of pixel bytes per frame.
REQ-003 Parameter HDR0, default 8'hAA, is the first sync byte.
REQ-004 Parameter HDR1, default 8'h55, is the second sync byte.
REQ-005 clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-006 n_rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 serialsend_flag, input, 1 bit: high while the writer is filling the FIFO with a frame.
REQ-008 rdreq, output, 1 bit: FIFO read request, one-cycle pulse per byte.
REQ-009 q, input, 8 bits: FIFO read data, valid on the cycle after the rdreq pulse.
REQ-010 rdempty, input, 1 bit: FIFO empty flag.
REQ-011 uart_tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-012 busy, output, 1 bit: high from frame start until the checksum stop bit ends.
REQ-013 frame_done, output, 1 bit: one-cycle pulse when the frame completes.

Function
REQ-014 The frame byte order shall be HDR0, HDR1, LEN[15:8], LEN[7:0], FRAME_LEN pixel bytes, then CHK.
REQ-015 LEN shall be FRAME_LEN as a 16-bit value.
REQ-016 CHK shall be the modulo-256 sum of the pixel bytes only, held in an 8-bit accumulator cleared at frame start.
REQ-017 The FSM states shall be IDLE, HDR0, HDR1, LENH, LENL, FETCH, WAITQ, DATA, SUM and DONE.
REQ-018 In IDLE, a rising edge of serialsend_flag (registered previous value is 0, current value is 1) shall move the FSM to HDR0 and set busy on the next cycle.
REQ-019 HDR0, HDR1, LENH, LENL and SUM shall each start one byte transmission and advance only when the byte's stop bit has completed.
REQ-020 In FETCH, when rdempty=0 the block shall pulse rdreq for one cycle and move to WAITQ; when rdempty=1 it shall hold with rdreq=0, with no timeout.
REQ-021 WAITQ shall last exactly one cycle, capturing q, adding q to CHK and incrementing the 11-bit byte counter.
REQ-022 DATA shall transmit the captured byte, then go to FETCH if count < FRAME_LEN, otherwise to SUM.
REQ-023 DONE shall pulse frame_done, clear busy, clear the counter and return to IDLE, all in one cycle.
REQ-024 A serialsend_flag edge while busy=1 shall be ignored and shall not be queued.
REQ-025 The UART byte timing shall be: start bit 0, data bits d0..d7, stop bit 1, each exactly CLK_DIV cycles; this gives 10*CLK_DIV cycles per byte.
REQ-026 Back-to-back bytes shall carry no extra idle bits except FIFO stall time in FETCH and the WAITQ cycle.
REQ-027 rdreq shall never be asserted while rdempty=1, and never outside FETCH.

Reset
REQ-028 While n_rst=0: uart_tx=1, rdreq=0, busy=0, frame_done=0, FSM=IDLE, and the counter, CHK, bit timer and registered serialsend_flag shall all be 0.
REQ-029 A reset mid-frame shall abort the frame immediately with no completion of the partial byte.
REQ-030 After release, a new frame shall require a fresh 0->1 edge on serialsend_flag.

Structure
REQ-031 The state encoding, HDR0/HDR1 defaults and default CLK_DIV shall live in the shared package ccd_pkg.
REQ-032 Serialisation shall be a sub-module uart_tx_byte (inputs start and byte[7:0]; outputs tx, busy and a done pulse), instantiated once.

Verification
REQ-033 FIFO preloaded with 1024 bytes of 0x01, then serialsend_flag 0->1 -> line shows AA 55 04 00, 1024 x 01, then 00; frame_done pulses once.
REQ-034 Bytes 0x00..0xFF repeated four times -> CHK = 0x00 and exactly 1024 rdreq pulses.
REQ-035 rdempty held at 1 for 5000 cycles after byte 10 -> uart_tx idle-high, rdreq=0, busy=1, then transmission resumes with byte 11 intact.
REQ-036 Second serialsend_flag edge mid-frame -> no extra header, exactly one frame_done.
REQ-037 n_rst pulsed low during the data bit d3 of pixel byte 500 -> uart_tx=1, busy=0 within the reset, and the next edge sends a full new frame starting AA 55.
REQ-038 CLK_DIV=4 -> every bit is exactly 4 cycles and each byte is 40 cycles start to stop end.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD frame sender: FSM encoding and defaults.
package ccd_pkg;

  localparam int unsigned CLK_DIV_DEF = 434;   // 50 MHz / 115200 baud
  localparam logic [7:0]  HDR0_DEF    = 8'hAA;
  localparam logic [7:0]  HDR1_DEF    = 8'h55;
  localparam int unsigned CNT_W       = 11;    // pixel counter, holds up to 1024

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LENH,
    ST_LENL,
    ST_FETCH,
    ST_WAITQ,
    ST_DATA,
    ST_SUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, d0..d7 LSB first, stop bit, CLK_DIV clk each.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV = 434
)(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = $clog2(CLK_DIV + 1);

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [8:0]    sh_q, sh_d;     // {stop, d7..d0}; sh[0] is the next bit out
  logic [3:0]    idx_q, idx_d;   // 0 = start, 1..8 = data, 9 = stop
  logic [TW-1:0] tmr_q, tmr_d;

  // Bit timer and shifter; start is only accepted while idle.
  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    idx_d  = idx_q;
    tmr_d  = tmr_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        tx_d   = 1'b0;
        sh_d   = {1'b1, byte_in};
        idx_d  = 4'd0;
        tmr_d  = '0;
      end
    end else if (tmr_q == TW'(CLK_DIV - 1)) begin
      tmr_d = '0;
      if (idx_q == 4'd9) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        tx_d   = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
        tx_d  = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
      end
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  // State registers; reset drops the line back to idle-high at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      sh_q   <= '1;
      idx_q  <= '0;
      tmr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      done_q <= done_d;
      sh_q   <= sh_d;
      idx_q  <= idx_d;
      tmr_q  <= tmr_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/ccd_frame_sender.sv
// Streams one FIFO frame over UART: AA 55 LENH LENL <pixels> CHK.
module ccd_frame_sender
  import ccd_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [7:0]  HDR0      = HDR0_DEF,
  parameter logic [7:0]  HDR1      = HDR1_DEF
)(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serialsend_flag,
  output logic       rdreq,
  input  logic [7:0] q,
  input  logic       rdempty,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] LEN = 16'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       txb_q, txb_d;
  logic             flag_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic             sent_q, sent_d;   // byte for the current state already launched
  logic             u_done, u_busy;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start_q),
    .byte_in (txb_q),
    .tx      (uart_tx),
    .busy    (u_busy),
    .done    (u_done)
  );

  // rdreq is combinational so the popped byte lands exactly in WAITQ and
  // can never be raised against an empty FIFO.
  assign rdreq = (state_q == ST_FETCH) && !rdempty;

  // Frame sequencing: each byte state launches one byte, waits for its stop bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    txb_d   = txb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    sent_d  = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (serialsend_flag && !flag_q) begin
          state_d = ST_HDR0;
          busy_d  = 1'b1;
          chk_d   = '0;
          cnt_d   = '0;
          sent_d  = 1'b0;
        end
      end
      ST_HDR0, ST_HDR1, ST_LENH, ST_LENL, ST_DATA, ST_SUM: begin
        if (!sent_q) begin
          start_d = 1'b1;
          sent_d  = 1'b1;
          case (state_q)
            ST_HDR0: txb_d = HDR0;
            ST_HDR1: txb_d = HDR1;
            ST_LENH: txb_d = LEN[15:8];
            ST_LENL: txb_d = LEN[7:0];
            ST_SUM:  txb_d = chk_q;
            default: txb_d = txb_q;  // DATA: byte captured in WAITQ
          endcase
        end else if (u_done) begin
          sent_d = 1'b0;
          case (state_q)
            ST_HDR0: state_d = ST_HDR1;
            ST_HDR1: state_d = ST_LENH;
            ST_LENH: state_d = ST_LENL;
            ST_LENL: state_d = ST_FETCH;
            ST_DATA: state_d = (cnt_q < CNT_W'(FRAME_LEN)) ? ST_FETCH : ST_SUM;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_FETCH: begin
        if (!rdempty) state_d = ST_WAITQ;
      end
      ST_WAITQ: begin
        txb_d   = q;
        chk_d   = chk_q + q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_DATA;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chk_q   <= '0;
      txb_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      txb_q   <= txb_d;
      flag_q  <= serialsend_flag;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      sent_q  <= sent_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ccd_frame_sender.sv
// Directed bench: FIFO model, UART line decoder, hand-computed frame contents.
module tb_ccd_frame_sender;

  localparam int CD    = 4;
  localparam int FL    = 32;
  localparam int STALL = 5000;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serialsend_flag = 1'b0;
  logic       rdempty = 1'b1;
  logic [7:0] q = 8'h00;
  logic       rdreq, uart_tx, busy, frame_done;

  ccd_frame_sender #(.CLK_DIV(CD), .FRAME_LEN(FL), .HDR0(8'hAA), .HDR1(8'h55)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .serialsend_flag (serialsend_flag),
    .rdreq           (rdreq),
    .q               (q),
    .rdempty         (rdempty),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO model: pop on rdreq, q valid the next cycle; optional stall window.
  logic [7:0] fifo[$];
  int pop_n = 0, stall_at = -1, stall_left = 0;
  always @(posedge clk) begin
    int sz;
    logic [7:0] t;
    sz = fifo.size();
    if (rdreq && sz > 0) begin
      t = fifo.pop_front();
      q <= t;
      sz--;
      pop_n = pop_n + 1;
      if (pop_n == stall_at) stall_left = STALL + 1;
    end
    if (stall_left > 0) stall_left = stall_left - 1;
    rdempty <= (sz == 0) || (stall_left > 0);
  end

  // Interface monitors.
  int rd_cnt = 0, rd_bad = 0, fd_cnt = 0, stall_seen = 0, stall_bad = 0;
  logic rdreq_prev = 1'b0;
  always @(negedge clk) begin
    if (rdreq && rdempty) rd_bad++;
    if (rdreq && rdreq_prev) rd_bad++;
    if (rdreq) rd_cnt++;
    if (frame_done) fd_cnt++;
    rdreq_prev = rdreq;
    if (stall_left > 0 && stall_left < STALL - 100) begin
      stall_seen++;
      if (uart_tx !== 1'b1 || rdreq !== 1'b0 || busy !== 1'b1) stall_bad++;
    end
  end

  // Line decoder: captures 10*CD samples per byte and checks each bit's width.
  logic [7:0] rxq[$];
  int rx_started = 0, tim_err = 0;
  initial begin : rx
    forever begin
      logic [10*CD-1:0] smp;
      logic [7:0] b;
      logic       eb;
      bit         ab;
      @(negedge clk);
      if (n_rst && uart_tx === 1'b0) begin
        rx_started++;
        ab = 0;
        smp = '0;
        for (int j = 1; j < 10*CD; j++) begin
          @(negedge clk);
          if (!n_rst) ab = 1;
          smp[j] = uart_tx;
        end
        if (!ab) begin
          for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*CD + CD/2];
          for (int j = 0; j < 10*CD; j++) begin
            if (j < CD) eb = 1'b0;
            else if (j >= 9*CD) eb = 1'b1;
            else eb = b[j/CD - 1];
            if (smp[j] !== eb) tim_err++;
          end
          rxq.push_back(b);
        end
      end
    end
  end

  logic [7:0] pix [FL];

  task automatic send_frame();
    rxq.delete();
    for (int i = 0; i < FL; i++) fifo.push_back(pix[i]);
    @(negedge clk);
    chk("busy_pre", busy, 0);
    serialsend_flag = 1'b1;
    @(negedge clk);
    chk("busy_start", busy, 1);
    repeat (2) @(negedge clk);
    serialsend_flag = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int n = 0;
    while (fd_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, fd_cnt > base, 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] ck);
    int bad = 0;
    chk({tag, "_nbytes"}, rxq.size(), FL + 5);
    if (rxq.size() == FL + 5) begin
      chk({tag, "_hdr0"}, rxq[0], 8'hAA);
      chk({tag, "_hdr1"}, rxq[1], 8'h55);
      chk({tag, "_lenh"}, rxq[2], 8'h00);
      chk({tag, "_lenl"}, rxq[3], 8'h20);
      for (int i = 0; i < FL; i++) if (rxq[4+i] !== pix[i]) bad++;
      chk({tag, "_pix"}, bad, 0);
      chk({tag, "_chk"}, rxq[FL+4], ck);
    end
  endtask

  initial begin : main
    int fb, rb, sb, n;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdreq", rdreq, 0);
    chk("rst_done", frame_done, 0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // A: all 0x01 -> CHK 0x20
    for (int i = 0; i < FL; i++) pix[i] = 8'h01;
    fb = fd_cnt; rb = rd_cnt;
    send_frame();
    wait_done(fb, 4000, "A_done");
    repeat (5) @(negedge clk);
    check_frame("A", 8'h20);
    chk("A_rdreq_n", rd_cnt - rb, FL);
    chk("A_done_n", fd_cnt - fb, 1);
    chk("A_busy_end", busy, 0);

    // B: 0x00,0x08..0xF8 -> CHK 0x80; second flag edge mid-frame is ignored
    for (int i = 0; i < FL; i++) pix[i] = 8'(i * 8);
    fb = fd_cnt; rb = rd_cnt; sb = rx_started;
    send_frame();
    n = 0;
    while (rx_started < sb + 10 && n < 4000) begin @(negedge clk); n++; end
    serialsend_flag = 1'b1;
    repeat (3) @(negedge clk);
    serialsend_flag = 1'b0;
    wait_done(fb, 4000, "B_done");
    repeat (600) @(negedge clk);
    check_frame("B", 8'h80);
    chk("B_done_n", fd_cnt - fb, 1);
    chk("B_rdreq_n", rd_cnt - rb, FL);
    chk("B_busy_end", busy, 0);

    // C: 0..31 with a 5000-cycle FIFO stall after the 10th pixel -> CHK 0xF0
    for (int i = 0; i < FL; i++) pix[i] = 8'(i);
    fb = fd_cnt;
    stall_at = pop_n + 10;
    send_frame();
    wait_done(fb, 12000, "C_done");
    stall_at = -1;
    repeat (5) @(negedge clk);
    check_frame("C", 8'hF0);
    if (rxq.size() > 14) chk("C_px11", rxq[14], 8'h0A);
    chk("C_stall_seen", stall_seen > 4000, 1);
    chk("C_stall_line", stall_bad, 0);

    // D: 0xFF pixels, reset during d3 of pixel 20 aborts the frame
    for (int i = 0; i < FL; i++) pix[i] = 8'hFF;
    fb = fd_cnt; sb = rx_started;
    send_frame();
    n = 0;
    while (rx_started < sb + 25 && n < 4000) begin @(negedge clk); n++; end
    chk("D_reach_px20", rx_started >= sb + 25, 1);
    repeat (4*CD + 1) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("D_rst_tx", uart_tx, 1);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_rdreq", rdreq, 0);
    @(negedge clk);
    chk("D_rst_done", frame_done, 0);
    fifo.delete();
    repeat (3) @(negedge clk);
    rxq.delete();
    n_rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("D_idle_busy", busy, 0);
    chk("D_idle_rx", rxq.size(), 0);
    chk("D_no_done", fd_cnt - fb, 0);

    // E: fresh edge after reset sends a complete frame
    for (int i = 0; i < FL; i++) pix[i] = 8'h01;
    fb = fd_cnt;
    send_frame();
    wait_done(fb, 4000, "E_done");
    repeat (5) @(negedge clk);
    check_frame("E", 8'h20);

    chk("rdreq_protocol", rd_bad, 0);
    chk("bit_timing", tim_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
